// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: width, seed, checker FSM states and the polynomial step
// x^8+x^4+x^3+x^2+1 in Galois form.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h01;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  // One Galois step: bit 7 feeds back into bits 0, 2, 3 and 4.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
    return {x[6], x[5], x[4], x[3] ^ x[7], x[2] ^ x[7], x[1] ^ x[7], x[0], x[7]};
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Word stream from the generator side plus lock/error status back from the checker.
interface lfsr_checker_if #(
  parameter int unsigned ERR_W = 16
);
  import lfsr_pkg::*;

  logic              i_valid;
  logic [LFSR_W-1:0] i_lfsr;
  logic              i_clr_err;
  logic              o_lock;
  logic              o_err;
  logic [ERR_W-1:0]  o_err_cnt;

  modport master (
    output i_valid, i_lfsr, i_clr_err,
    input  o_lock, o_err, o_err_cnt
  );

  modport slave (
    input  i_valid, i_lfsr, i_clr_err,
    output o_lock, o_err, o_err_cnt
  );

endinterface

// File: rtl/lfsr_checker.sv
// PRBS receive checker: self-synchronises to the LFSR word stream, declares lock,
// then counts mismatching words while locked.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned ERR_W    = 16
) (
  input  logic           clk,
  input  logic           i_rst,
  lfsr_checker_if.slave  bus
);

  localparam int unsigned CNT_W = 4;

  chk_state_e        state_q, state_d;
  logic [LFSR_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic              lock_q, lock_d;
  logic              err_q, err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic [LFSR_W-1:0] word;
  logic              word_zero;
  logic              word_ok;

  assign word      = bus.i_lfsr;
  assign word_zero = (word == '0);
  assign word_ok   = (word == exp_q);

  // Next-state, expected-word tracking and error accounting.
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (bus.i_valid) begin
      unique case (state_q)
        ST_SEARCH: begin
          // All-zero is the LFSR lockup state and can never seed.
          if (!word_zero) begin
            exp_d       = lfsr_next(word);
            match_cnt_d = '0;
            state_d     = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (word_zero) begin
            state_d = ST_SEARCH;
          end else if (word_ok) begin
            exp_d       = lfsr_next(word);
            match_cnt_d = match_cnt_q + CNT_W'(1);
            if (match_cnt_q == CNT_W'(LOCK_CNT - 1)) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            exp_d       = lfsr_next(word);
            match_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          // Free-run the reference so a corrupted word never reseeds it.
          exp_d = lfsr_next(exp_q);
          if (word_ok) begin
            miss_cnt_d = '0;
          end else begin
            err_d      = 1'b1;
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (miss_cnt_q == CNT_W'(LOSS_CNT - 1)) state_d = ST_SEARCH;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    if (bus.i_clr_err) err_cnt_d = '0;

    lock_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= ST_SEARCH;
      exp_q       <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      lock_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      lock_q      <= lock_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.o_lock    = lock_q;
  assign bus.o_err     = err_q;
  assign bus.o_err_cnt = err_cnt_q;

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Downstream consumer of the 8-bit Galois LFSR generator (polynomial x^8+x^4+x^3+x^2+1, feedback from bit 7 into bits 0, 2, 3 and 4). It self-synchronises to the incoming word stream, declares lock after a run of correct words, then counts mismatching words. It sits at the receive end of the PRBS test path and is the pass/fail monitor for any link or stage between generator and checker.

## Interface
- LOCK_CNT, 4, consecutive correct words (after the seed word) required to enter LOCKED; range 1..15
- LOSS_CNT, 4, consecutive wrong words in LOCKED that drop lock; range 1..15
- ERR_W, 16, width of the error counter
- clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  i_lfsr carries a word this cycle
- i_lfsr  in  8  received LFSR word
- i_clr_err  in  1  synchronous clear of o_err_cnt
- o_lock  out  1  checker is in LOCKED
- o_err  out  1  one-cycle pulse per mismatching word while LOCKED
- o_err_cnt  out  ERR_W  saturating count of mismatching words while LOCKED

## Operation
- next(x): n0=x7, n1=x0, n2=x1^x7, n3=x2^x7, n4=x3^x7, n5=x4, n6=x5, n7=x6.
- Internal state: FSM {SEARCH, SYNC, LOCKED}, exp[7:0], match_cnt[3:0], miss_cnt[3:0].
- i_valid=0: state, exp and counters hold; o_err=0.
- SEARCH, valid word w: w==0 → stay (all-zero is the lockup state, never a seed); else exp<=next(w), match_cnt<=0, go SYNC.
- SYNC, valid w: w==0 → SEARCH. w==exp → exp<=next(w), match_cnt+1; if match_cnt==LOCK_CNT-1 go LOCKED with miss_cnt<=0. w!=exp (nonzero) → reseed: exp<=next(w), match_cnt<=0, stay SYNC. No errors are counted in SYNC.
- LOCKED, valid w: exp<=next(exp) always (free-run; a corrupted word never reseeds). w==exp → miss_cnt<=0. w!=exp → o_err pulse, o_err_cnt+1 saturating at all-ones, miss_cnt+1; if miss_cnt==LOSS_CNT-1 go SEARCH.
- Lock loss does not clear o_err_cnt; only i_rst or i_clr_err do.
- i_clr_err and a counted error in the same cycle: clear wins, counter reads 0.

## Timing
- Reset: state SEARCH, exp=0, counters 0, o_lock=0, o_err=0, o_err_cnt=0.
- o_lock, o_err, o_err_cnt are registered; each reflects the word sampled on the previous rising edge (latency 1).
- Back-to-back valid words fully supported; throughput one word per cycle. Gaps in i_valid are transparent.
- Minimum lock time: LOCK_CNT+1 valid words after the first nonzero word; o_lock rises the cycle after the last one.
- o_lock falls the cycle after the LOSS_CNT-th consecutive miss; that word still pulses o_err and increments the count.
- i_rst mid-stream: next cycle in SEARCH regardless of i_valid, i_clr_err; the word presented in the reset cycle is discarded.

## Structure
- Shared package lfsr_pkg: LFSR_W=8, LFSR_SEED=8'h01, FSM state typedef, function lfsr_next implementing next(x), so generator and checker share one polynomial definition.
- No sub-module: comparator, FSM and counters are a single module; the step is the package function.

## Test plan
- Reset, then stream 01,02,04,08,10 every cycle (LOCK_CNT=4) → o_lock=1 one cycle after 10; then 20,40,80,1D → o_err never pulses, o_err_cnt=0.
- Locked, replace expected 1D with 1C once, resume correct sequence (3A next) → single o_err pulse, o_err_cnt=1, o_lock stays 1.
- Locked, feed 4 consecutive wrong words (LOSS_CNT=4) → o_err_cnt=4, o_lock=0 cycle after 4th; correct stream afterwards → relock after 5 words, count still 4.
- Stream 00 words, then 01,02,… → no SYNC on zeros; lock only after 01..10; corrupt word during SYNC (01,02,FF,…) → reseed, match_cnt restarts, no error counted.
- ERR_W=4, force 20 errors with LOSS_CNT=15 re-locking as needed → o_err_cnt saturates at 15; assert i_clr_err together with an error → counter 0.
- Locked stream with i_valid toggling 1/0 every cycle, then i_rst high mid-stream → lock and zero errors with gaps; after reset o_lock=0, o_err_cnt=0, state SEARCH.
